// File: rtl/psum_binarize_pack.sv
// Binarizes popped partial sums against per-channel thresholds and packs the sign bits
// LSB-first into PACK-bit words. Optional build macro SIGN_FLIP_EN adds a per-channel polarity bit.
module psum_binarize_pack #(
    parameter int WIDTH          = 14,
    parameter int O_CH           = 64,
    parameter int OUT_ROW_LENGTH = 4,
    parameter int PACK           = 9
) (
    input  logic             clk_in,
    input  logic             rst_in,
    input  logic             thr_load_in,
    input  logic [WIDTH-1:0] thr_in,
    input  logic             thr_flip_in,
    input  logic             in_valid_in,
    input  logic [WIDTH-1:0] sum_in,
    output logic [PACK-1:0]  word_out,
    output logic             word_valid_out,
    output logic             frame_last_out,
    output logic             err_out
);
    localparam int CW = (O_CH > 1) ? $clog2(O_CH) : 1;
    localparam int PW = (OUT_ROW_LENGTH > 1) ? $clog2(OUT_ROW_LENGTH) : 1;
    localparam int BW = $clog2(PACK + 1);
    localparam logic [CW-1:0] LAST_CH  = CW'(O_CH - 1);
    localparam logic [PW-1:0] LAST_POS = PW'(OUT_ROW_LENGTH - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(PACK - 1);

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t                  state, state_nx;
    logic [CW-1:0]           ld_idx, wr_idx, ch;
    logic [PW-1:0]           pos;
    logic [BW-1:0]           bit_cnt;
    logic [PACK-1:0]         pack, pack_nx;
    logic signed [WIDTH-1:0] thr [O_CH];
    logic                    thr_ready;
    logic                    load_wr, accept, err_set, frame_end, cmp_ge, bin_bit;

`ifdef SIGN_FLIP_EN
    logic flip [O_CH];
    assign bin_bit = flip[ch] ? ~cmp_ge : cmp_ge;
`else
    logic unused_flip;
    assign unused_flip = thr_flip_in;
    assign bin_bit     = cmp_ge;
`endif

    assign cmp_ge    = $signed(sum_in) >= thr[ch];
    assign frame_end = (ch == LAST_CH) && (pos == LAST_POS);
    // a fresh load sequence always begins at entry 0
    assign wr_idx    = (state == IDLE) ? '0 : ld_idx;
    assign pack_nx   = pack | (PACK'(bin_bit) << bit_cnt);
    assign err_set   = (in_valid_in && (!thr_ready || thr_load_in)) ||
                       (thr_load_in && state == RUN);

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        load_wr  = 1'b0;
        accept   = 1'b0;
        case (state)
            IDLE: begin
                if (thr_load_in) begin
                    load_wr  = 1'b1;
                    state_nx = LOAD;
                end else if (in_valid_in && thr_ready) begin
                    accept   = 1'b1;
                    state_nx = RUN;
                end
            end
            LOAD: load_wr = thr_load_in;
            RUN:  accept  = in_valid_in && !thr_load_in;
            default: state_nx = IDLE;
        endcase
        if (load_wr && wr_idx == LAST_CH) state_nx = IDLE;
        if (accept && frame_end)          state_nx = IDLE;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            for (int i = 0; i < O_CH; i++) begin
                thr[i] <= '0;
`ifdef SIGN_FLIP_EN
                flip[i] <= 1'b0;
`endif
            end
            thr_ready      <= 1'b0;
            ld_idx         <= '0;
            ch             <= '0;
            pos            <= '0;
            bit_cnt        <= '0;
            pack           <= '0;
            word_out       <= '0;
            word_valid_out <= 1'b0;
            frame_last_out <= 1'b0;
            err_out        <= 1'b0;
        end else begin
            word_valid_out <= 1'b0;
            frame_last_out <= 1'b0;
            word_out       <= '0;
            if (err_set) err_out <= 1'b1;

            if (load_wr) begin
                thr[wr_idx] <= thr_in;
`ifdef SIGN_FLIP_EN
                flip[wr_idx] <= thr_flip_in;
`endif
                if (wr_idx == LAST_CH) begin
                    ld_idx    <= '0;
                    thr_ready <= 1'b1;
                end else begin
                    ld_idx    <= wr_idx + 1'b1;
                    thr_ready <= 1'b0;
                end
            end

            if (accept) begin
                // the frame's last input flushes a partial word with zero upper bits
                if (frame_end || bit_cnt == LAST_BIT) begin
                    word_out       <= pack_nx;
                    word_valid_out <= 1'b1;
                    frame_last_out <= frame_end;
                    pack           <= '0;
                    bit_cnt        <= '0;
                end else begin
                    pack    <= pack_nx;
                    bit_cnt <= bit_cnt + 1'b1;
                end
                if (pos == LAST_POS) begin
                    pos <= '0;
                    ch  <= frame_end ? '0 : ch + 1'b1;
                end else begin
                    pos <= pos + 1'b1;
                end
            end
        end
    end
endmodule
